jt89_lfsr_noise: RTL

JT89_LFSR_NOISE -- requirements
Module: jt89_lfsr_noise

---
 rtl/jt89_pkg.sv | 49 ++++
 rtl/jt89_noise_att.sv | 23 ++
 rtl/jt89_lfsr_noise.sv | 88 ++++++++
 3 files changed

// File: rtl/jt89_pkg.sv
// Shared constants for the SN76489-style noise channel: rate encodings, reload
// counts, default LFSR taps/seed and the 2 dB attenuation table.
package jt89_pkg;

  typedef enum logic [1:0] {
    RATE_16    = 2'd0,
    RATE_32    = 2'd1,
    RATE_64    = 2'd2,
    RATE_TONE2 = 2'd3
  } rate_e;

  localparam int RELOAD_16 = 16;
  localparam int RELOAD_32 = 32;
  localparam int RELOAD_64 = 64;

  localparam logic [15:0] DEF_TAP_MASK = 16'h0009;

  localparam int          SND_W   = 9;
  localparam logic [8:0]  SND_MAX = 9'h1FF;

  // Default seed is a single 1 in the MSB for any LFSR length.
  function automatic logic [31:0] def_seed(input int w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [8:0] att_lookup(input logic [3:0] vol);
    logic [8:0] a;
    case (vol)
      4'd0:    a = 9'd511;
      4'd1:    a = 9'd406;
      4'd2:    a = 9'd322;
      4'd3:    a = 9'd256;
      4'd4:    a = 9'd203;
      4'd5:    a = 9'd161;
      4'd6:    a = 9'd128;
      4'd7:    a = 9'd102;
      4'd8:    a = 9'd81;
      4'd9:    a = 9'd64;
      4'd10:   a = 9'd51;
      4'd11:   a = 9'd40;
      4'd12:   a = 9'd32;
      4'd13:   a = 9'd25;
      4'd14:   a = 9'd20;
      default: a = 9'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/jt89_noise_att.sv
// Registered 2 dB-step attenuator for the noise channel output.
// Only compiled when JT89_NOISE_ATT_EN is defined.
`ifdef JT89_NOISE_ATT_EN
module jt89_noise_att
  import jt89_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [3:0]       vol,
  input  logic             din,
  output logic [SND_W-1:0] snd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      snd <= '0;
    else if (clk_en)
      snd <= din ? att_lookup(vol) : '0;
  end

endmodule
`endif

// File: rtl/jt89_lfsr_noise.sv
// Noise channel: rate counter, half-rate phase flag, Galois-free shift LFSR and
// output stage. JT89_NOISE_ATT_EN selects the 2 dB attenuator; otherwise on/off gating.
module jt89_lfsr_noise
  import jt89_pkg::*;
#(
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(DEF_TAP_MASK),
  parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(def_seed(LFSR_W)),
  parameter int                CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             clr,
  input  logic [2:0]       ctrl3,
  input  logic [CNT_W-1:0] tone2,
  input  logic [3:0]       vol,
  output logic             noise_out,
  output logic [SND_W-1:0] snd
);

  logic [LFSR_W-1:0] shift;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  reload;
  logic              v;
  logic              terminal;
  logic              advance;
  logic              fb;

  // ctrl3 is only sampled here, so a new rate lands at the next reload.
  always_comb begin
    reload = tone2;
    case (ctrl3[1:0])
      RATE_16: reload = CNT_W'(RELOAD_16);
      RATE_32: reload = CNT_W'(RELOAD_32);
      RATE_64: reload = CNT_W'(RELOAD_64);
      default: reload = tone2;
    endcase
  end

  assign terminal  = clk_en && (cnt <= CNT_W'(1));
  assign advance   = terminal && v;
  assign fb        = ctrl3[2] ? ^(shift & TAP_MASK) : shift[0];
  assign noise_out = shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_W'(1);
      v   <= 1'b0;
    end else if (clk_en) begin
      if (terminal) begin
        cnt <= reload;
        v   <= ~v;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // clr wins over an advance; an all-zero register re-enters from SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shift <= SEED;
    else if (clr)
      shift <= SEED;
    else if (advance)
      shift <= (shift == '0) ? SEED : {fb, shift[LFSR_W-1:1]};
  end

`ifdef JT89_NOISE_ATT_EN
  jt89_noise_att u_att (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .vol    (vol),
    .din    (noise_out),
    .snd    (snd)
  );
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      snd <= '0;
    else if (clk_en)
      snd <= (noise_out && (vol != 4'hF)) ? SND_MAX : '0;
  end
`endif

endmodule
